// File: rtl/axis_header_insert_var.sv
// AXI-Stream header inserter: prepends a per-packet 0..MAX_HEADER_BYTES header,
// shifts the payload up and emits one trailing beat when the shifted tail overflows.
module axis_header_insert_var #(
    parameter int DATA_WIDTH       = 512,
    parameter int MAX_HEADER_BYTES = 14,
    parameter int HL_W             = $clog2(MAX_HEADER_BYTES + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [8*MAX_HEADER_BYTES-1:0] header_data,
    input  logic [HL_W-1:0]               header_len,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic [DATA_WIDTH-1:0]         s_tdata,
    input  logic [DATA_WIDTH/8-1:0]       s_tkeep,
    input  logic                          s_tlast,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic [DATA_WIDTH/8-1:0]       m_tkeep,
    output logic                          m_tlast,
    output logic                          hdr_len_err,
    output logic [1:0]                    dbg_state
);
    localparam int B  = DATA_WIDTH / 8;
    localparam int HW = 8 * MAX_HEADER_BYTES;
    localparam int CW = $clog2(B + 1);
    localparam logic [HL_W-1:0] MAX_H = HL_W'(MAX_HEADER_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [HL_W-1:0]         h_q, h_d;
    logic [HW-1:0]           left_q, left_d;
    logic [CW-1:0]           flush_n_q, flush_n_d;
    logic                    m_tvalid_d, m_tlast_d, err_d;
    logic [DATA_WIDTH-1:0]   m_tdata_d;
    logic [B-1:0]            m_tkeep_d;
    logic                    out_free, accept;
    int                      h_cur, n;
    logic [HW-1:0]           prefix, left_next;
    logic [DATA_WIDTH-1:0]   shifted;
    logic [B-1:0]            fkeep, lkeep;

    function automatic logic [B-1:0] low_mask(input int k);
        logic [B-1:0] r;
        for (int i = 0; i < B; i++) r[i] = (i < k);
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] expand(input logic [B-1:0] k);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < B; i++) r[8*i +: 8] = {8{k[i]}};
        return r;
    endfunction

    // Handshake: a beat moves on either side only when valid && ready are both high
    // at a rising edge; m_* are held stable while m_tvalid && !m_tready.
    assign out_free  = !m_tvalid || m_tready;
    assign s_tready  = (state_q != FLUSH) && out_free;
    assign accept    = s_tvalid && s_tready;
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        left_d     = left_q;
        flush_n_d  = flush_n_q;
        m_tvalid_d = m_tvalid && !m_tready;
        m_tdata_d  = m_tdata;
        m_tkeep_d  = m_tkeep;
        m_tlast_d  = m_tlast;
        err_d      = 1'b0;
        fkeep      = '0;
        lkeep      = '0;
        left_next  = '0;

        // Header length and prefix bytes come from the ports only on a first beat.
        if (state_q == IDLE) begin
            h_cur  = (header_len > MAX_H) ? MAX_HEADER_BYTES : int'(header_len);
            prefix = header_data;
        end else begin
            h_cur  = int'(h_q);
            prefix = left_q;
        end

        n = 0;
        for (int i = 0; i < B; i++) n = n + int'(s_tkeep[i]);

        shifted = (s_tdata << (8 * h_cur))
                | ({{(DATA_WIDTH - HW){1'b0}}, prefix} & expand(low_mask(h_cur)));
        for (int i = 0; i < MAX_HEADER_BYTES; i++) begin
            if (i < h_cur) left_next[8*i +: 8] = s_tdata[8*(B - h_cur + i) +: 8];
        end

        if (accept) begin
            m_tvalid_d = 1'b1;
            h_d        = HL_W'(h_cur);
            left_d     = left_next;
            if (state_q == IDLE) err_d = (header_len > MAX_H);
            if (!s_tlast) begin
                m_tdata_d = shifted;
                m_tkeep_d = '1;
                m_tlast_d = 1'b0;
                state_d   = PASS;
            end else if (n <= B - h_cur) begin
                lkeep     = low_mask(h_cur + n);
                m_tdata_d = shifted & expand(lkeep);
                m_tkeep_d = lkeep;
                m_tlast_d = 1'b1;
                state_d   = IDLE;
            end else begin
                m_tdata_d = shifted;
                m_tkeep_d = '1;
                m_tlast_d = 1'b0;
                flush_n_d = CW'(n - (B - h_cur));
                state_d   = FLUSH;
            end
        end else if (state_q == FLUSH && out_free) begin
            fkeep      = low_mask(int'(flush_n_q));
            m_tvalid_d = 1'b1;
            m_tdata_d  = {{(DATA_WIDTH - HW){1'b0}}, left_q} & expand(fkeep);
            m_tkeep_d  = fkeep;
            m_tlast_d  = 1'b1;
            state_d    = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            h_q       <= '0;
            left_q    <= '0;
            flush_n_q <= '0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            left_q    <= left_d;
            flush_n_q <= flush_n_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m_tvalid    <= 1'b0;
            m_tdata     <= '0;
            m_tkeep     <= '0;
            m_tlast     <= 1'b0;
            hdr_len_err <= 1'b0;
        end else begin
            m_tvalid    <= m_tvalid_d;
            m_tdata     <= m_tdata_d;
            m_tkeep     <= m_tkeep_d;
            m_tlast     <= m_tlast_d;
            hdr_len_err <= err_d;
        end
    end
endmodule

// File: tb/tb_axis_header_insert_var.sv
// Bench for axis_header_insert_var: byte-stream reference model feeding an expected
// queue, with a negedge monitor that pops and compares every output handshake.
module tb_axis_header_insert_var;
    localparam int DW   = 64;
    localparam int B    = 8;
    localparam int MHB  = 6;
    localparam int HL_W = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [8*MHB-1:0]  header_data = '0;
    logic [HL_W-1:0]   header_len = '0;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic [DW-1:0]     s_tdata = '0;
    logic [B-1:0]      s_tkeep = '0;
    logic              s_tlast = 1'b0;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic [DW-1:0]     m_tdata;
    logic [B-1:0]      m_tkeep;
    logic              m_tlast;
    logic              hdr_len_err;
    logic [1:0]        dbg_state;

    axis_header_insert_var #(
        .DATA_WIDTH(DW),
        .MAX_HEADER_BYTES(MHB)
    ) dut (
        .clock(clock), .reset(reset),
        .header_data(header_data), .header_len(header_len),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .hdr_len_err(hdr_len_err), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;
    int err_cycles = 0;
    logic [DW+B:0] exp_q[$];
    logic [7:0] pay[$];
    logic [8*MHB-1:0] hdr_cfg = 48'h060504030201;
    bit prev_flush = 1'b0;
    int rdy_mode = 0;
    int pat_i = 0;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output ready: 0 always ready, 1 fixed pattern, 2 random, 3 stalled.
    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0: m_tready = 1'b1;
            1: begin m_tready = pat[pat_i]; pat_i = (pat_i + 1) % 6; end
            2: m_tready = ($urandom_range(0, 3) != 0);
            default: m_tready = 1'b0;
        endcase
    end

    logic          hold_v = 1'b0;
    logic [DW+B+1:0] hold_snap = '0;
    always @(negedge clock) begin
        logic [DW+B:0] e;
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                check("stall_stable", {m_tvalid, m_tlast, m_tkeep, m_tdata}, hold_snap);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got 0x%0h expected none", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("out_beat", {m_tlast, m_tkeep, m_tdata}, e);
                end
            end
            hold_v    = m_tvalid && !m_tready;
            hold_snap = {m_tvalid, m_tlast, m_tkeep, m_tdata};
        end
        if (hdr_len_err) err_cycles++;
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic [B-1:0] k, input logic l,
                             output int waited);
        waited = 0;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
        forever begin
            @(negedge clock);
            if (s_tready) break;
            waited++;
            if (waited > 200) begin
                checks++; errors++;
                $display("FAIL accept_timeout: got no s_tready expected within 200 cycles");
                break;
            end
        end
        @(posedge clock);
        #1;
        s_tvalid = 1'b0;
    endtask

    // Reference: output byte stream = header[0..H-1] followed by payload, cut into B-byte beats.
    task automatic send_packet(input int hl, input int max_beats, input bit chk_wait, input bit chk_lat);
        int h, nb, nout, w, exp_w;
        logic [7:0] st[$];
        logic [DW-1:0] d;
        logic [B-1:0] k;
        logic l;
        logic [63:0] tmp;
        h = (hl > MHB) ? MHB : hl;
        st = {};
        for (int i = 0; i < h; i++) st.push_back(hdr_cfg[8*i +: 8]);
        foreach (pay[i]) st.push_back(pay[i]);
        nout = (st.size() + B - 1) / B;
        for (int b = 0; b < nout; b++) begin
            d = '0; k = '0;
            for (int j = 0; j < B; j++) begin
                if (B*b + j < st.size()) begin
                    d[8*j +: 8] = st[B*b + j];
                    k[j] = 1'b1;
                end
            end
            exp_q.push_back({(b == nout - 1), k, d});
        end
        if (hl > MHB) exp_err++;
        header_data = hdr_cfg;
        header_len  = HL_W'(hl);
        nb = (pay.size() + B - 1) / B;
        for (int b = 0; b < nb; b++) begin
            if (max_beats > 0 && b >= max_beats) break;
            for (int j = 0; j < B; j++) begin
                if (B*b + j < pay.size()) begin
                    d[8*j +: 8] = pay[B*b + j];
                    k[j] = 1'b1;
                end else begin
                    d[8*j +: 8] = 8'($urandom);
                    k[j] = 1'b0;
                end
            end
            l = (b == nb - 1);
            send_beat(d, k, l, w);
            if (chk_wait) begin
                exp_w = (b == 0 && prev_flush) ? 1 : 0;
                check("accept_wait", w, exp_w);
            end
            if (chk_lat) begin
                check("lat_valid", m_tvalid, 1);
                check("lat_data", m_tdata, d);
            end
            if (b == 0) begin
                if (hl > MHB) check("hdr_len_err_pulse", hdr_len_err, 1);
                header_len  = HL_W'($urandom);
                tmp         = {$urandom, $urandom};
                header_data = tmp[8*MHB-1:0];
            end
        end
        prev_flush = (nout > nb);
    endtask

    task automatic drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 2000) begin
            @(negedge clock);
            c++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic load_case1();
        pay = {};
        for (int i = 0; i < 8; i++) pay.push_back(8'(8'h11 + i));
        for (int i = 0; i < 4; i++) pay.push_back(8'(8'h21 + i));
    endtask

    task automatic load_case2();
        pay = {};
        for (int i = 0; i < 8; i++) pay.push_back(8'((i + 1) * 17));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tkeep", m_tkeep, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_hdr_len_err", hdr_len_err, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b0;
        @(negedge clock);
        check("rst_s_tready", s_tready, 1);
        @(posedge clock); #1;

        load_case1();
        send_packet(2, 0, 1'b0, 1'b0);
        drain();

        load_case2();
        send_packet(6, 0, 1'b0, 1'b0);
        @(negedge clock);
        check("flush_bubble", s_tready, 0);
        @(negedge clock);
        check("flush_bubble_end", s_tready, 1);
        drain();

        pay = {};
        for (int i = 0; i < 24; i++) pay.push_back(8'($urandom));
        send_packet(0, 0, 1'b0, 1'b1);
        drain();

        pat_i = 0;
        rdy_mode = 1;
        load_case1();
        send_packet(2, 0, 1'b0, 1'b0);
        drain();
        rdy_mode = 0;
        m_tready = 1'b1;

        load_case2();
        send_packet(7, 0, 1'b0, 1'b0);
        drain();

        rdy_mode = 3;
        m_tready = 1'b0;
        load_case1();
        send_packet(2, 1, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("rst_mid_tvalid", m_tvalid, 0);
        exp_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        rdy_mode = 0;
        m_tready = 1'b1;
        @(negedge clock);
        check("rst_mid_tready", s_tready, 1);
        @(posedge clock); #1;
        load_case2();
        send_packet(6, 0, 1'b0, 1'b0);
        drain();

        rdy_mode = 2;
        for (int p = 0; p < 40; p++) begin
            pay = {};
            for (int i = 0; i < $urandom_range(1, 24); i++) pay.push_back(8'($urandom));
            send_packet($urandom_range(0, 7), 0, 1'b0, 1'b0);
        end
        drain();

        rdy_mode = 0;
        m_tready = 1'b1;
        drain();
        prev_flush = 1'b0;
        for (int p = 0; p < 20; p++) begin
            pay = {};
            for (int i = 0; i < $urandom_range(1, 24); i++) pay.push_back(8'($urandom));
            send_packet($urandom_range(0, 7), 0, 1'b1, 1'b0);
        end
        drain();

        check("hdr_err_cycles", err_cycles, exp_err);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
